sb_rx_msg_queue: RTL and testbench
==================================

SB_RX_MSG_QUEUE -- requirements
Module: sb_rx_msg_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, receive FIFO entry count; power of two, 2..16.
REQ-002 SHALL have port clk_100MHz  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port enable_i  input  1  gates request servicing; low = requests ignored, enqueue still active.
REQ-005 SHALL have port flush_i  input  1  synchronous clear of FIFO and pending request.
REQ-006 SHALL have port deser_msg_i  input  SB_msg_t  decoded sideband header from the deserializer.
REQ-007 SHALL have port deser_data_i  input  64  payload accompanying deser_msg_i.
REQ-008 SHALL have port deser_valid_i  input  1  one-cycle strobe; one strobe = one message.
REQ-009 SHALL have port SB_RX_msg_req_i  input  1  consumer (LTSM state) request for next message.
REQ-010 SHALL have port SB_RX_msg_o  output  SB_msg_t  delivered header.
REQ-011 SHALL have port SB_RX_dataBus_o  output  64  delivered payload.
REQ-012 SHALL have port SB_RX_msg_valid_o  output  1  one-cycle delivery strobe.
REQ-013 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port overflow_o  output  1  sticky: message dropped on full FIFO.

Function
REQ-015 SHALL enqueue {deser_msg_i, deser_data_i} on every cycle deser_valid_i=1 and FIFO not full (or full with same-cycle pop).
REQ-016 SHALL drop the incoming message when full with no same-cycle pop, set overflow_o=1, hold it until reset or flush_i.
REQ-017 SHALL use wrap-around read/write pointers modulo DEPTH; count_o = writes - pops, never exceeds DEPTH.
REQ-018 SHALL implement FSM IDLE, WAIT, DELIVER.
REQ-019 IDLE: SB_RX_msg_req_i=1 and enable_i=1 -> DELIVER if count_o>0, else WAIT.
REQ-020 WAIT: stay until count_o>0 (including entry written this cycle visible next cycle), then DELIVER; further req pulses in WAIT are absorbed (no queuing of requests).
REQ-021 DELIVER: for exactly one cycle drive SB_RX_msg_valid_o=1 with FIFO head on SB_RX_msg_o/SB_RX_dataBus_o, pop head, return to IDLE.
REQ-022 Latency: req with non-empty FIFO -> valid 2 cycles after req sampled (cycle N req, N+1 DELIVER registered, valid visible N+1 output of DELIVER register); exactly one message per request.
REQ-023 SB_RX_msg_valid_o, SB_RX_msg_o, SB_RX_dataBus_o SHALL be registered outputs; when valid=0 msg SHALL equal reset_SB_msg() and data 0.
REQ-024 Request arriving in DELIVER cycle SHALL be ignored; consumer re-requests after valid.
REQ-025 Simultaneous enqueue and pop SHALL both take effect; count_o unchanged.
REQ-026 enable_i=0 in WAIT SHALL return FSM to IDLE, dropping the pending request; FIFO contents kept.
REQ-027 flush_i=1 SHALL empty FIFO, clear overflow_o, force IDLE, suppress valid that cycle; flush has priority over enqueue in the same cycle.
REQ-028 Messages SHALL be delivered in arrival order, no duplication, no loss except REQ-016 drops.

Reset
REQ-029 reset=1 SHALL force FSM IDLE, pointers 0, count_o=0, overflow_o=0, SB_RX_msg_valid_o=0, SB_RX_msg_o=reset_SB_msg(), SB_RX_dataBus_o=0.
REQ-030 reset mid-WAIT or mid-DELIVER SHALL abandon the request with no valid strobe; reset has priority over flush_i and enqueue.

Verification
REQ-031 Enqueue msg_num=SBINIT_out_of_reset, then req pulse -> one valid strobe carrying it, count_o 1->0.
REQ-032 req on empty FIFO, message SBINIT_done_req arrives 5 cycles later -> single valid strobe after arrival, none before.
REQ-033 DEPTH=4: enqueue 5 messages, no req -> count_o=4, overflow_o=1, 4 requests return messages 1-4 in order, 5th lost.
REQ-034 Full FIFO, enqueue coincides with DELIVER pop -> no overflow, count_o stays 4, order preserved.
REQ-035 Two messages queued, flush_i pulse then req -> WAIT, no delivery until new message; overflow_o cleared.
REQ-036 reset asserted in DELIVER-entry cycle -> SB_RX_msg_valid_o never asserts, all outputs at reset values next cycle.

Source files
------------

// File: rtl/sb_rx_msg_queue_if.sv
// Sideband RX message types and the queue's deserializer/consumer bus.
// Ports: deser_* (in), SB_RX_msg_req_i (in), SB_RX_msg_o/dataBus_o/msg_valid_o (out).
package sb_pkg;

    typedef enum logic [7:0] {
        SB_MSG_NONE         = 8'h00,
        SBINIT_out_of_reset = 8'h01,
        SBINIT_done_req     = 8'h02,
        SBINIT_done_resp    = 8'h03,
        MBINIT_param_req    = 8'h04,
        MBINIT_param_resp   = 8'h05
    } SB_msg_num_t;

    typedef struct packed {
        SB_msg_num_t msg_num;
        logic [15:0] msg_info;
    } SB_msg_t;

    function automatic SB_msg_t reset_SB_msg();
        SB_msg_t m;
        m.msg_num  = SB_MSG_NONE;
        m.msg_info = '0;
        return m;
    endfunction

endpackage

interface sb_rx_msg_queue_if;
    import sb_pkg::*;

    SB_msg_t     deser_msg_i;
    logic [63:0] deser_data_i;
    logic        deser_valid_i;
    logic        SB_RX_msg_req_i;
    SB_msg_t     SB_RX_msg_o;
    logic [63:0] SB_RX_dataBus_o;
    logic        SB_RX_msg_valid_o;

    modport master (
        output deser_msg_i,
        output deser_data_i,
        output deser_valid_i,
        output SB_RX_msg_req_i,
        input  SB_RX_msg_o,
        input  SB_RX_dataBus_o,
        input  SB_RX_msg_valid_o
    );

    modport slave (
        input  deser_msg_i,
        input  deser_data_i,
        input  deser_valid_i,
        input  SB_RX_msg_req_i,
        output SB_RX_msg_o,
        output SB_RX_dataBus_o,
        output SB_RX_msg_valid_o
    );

endinterface

// File: rtl/sb_rx_msg_queue.sv
// Sideband RX FIFO: buffers deserialized messages, hands one out per request.
// Ports: clk_100MHz, reset, enable_i, flush_i, bus (slave), count_o, overflow_o.
module sb_rx_msg_queue
    import sb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_100MHz,
    input  logic                     reset,
    input  logic                     enable_i,
    input  logic                     flush_i,
    sb_rx_msg_queue_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = $bits(SB_msg_t) + 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    SB_msg_t       head_msg;
    logic [63:0]   head_data;
    SB_msg_t       msg_q;
    logic [63:0]   data_q;
    logic          valid_q;

    assign full = (count_q == CW'(DEPTH));
    assign {head_msg, head_data} = mem[rd_ptr];

    // A full FIFO still accepts a write when the head leaves this cycle.
    assign push = bus.deser_valid_i && (!full || pop) && !flush_i;
    assign drop = bus.deser_valid_i && full && !pop && !flush_i;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.SB_RX_msg_req_i && enable_i)
                    state_d = (count_q != '0) ? DELIVER : WAIT;
            end
            WAIT: begin
                if (!enable_i)
                    state_d = IDLE;
                else if (count_q != '0)
                    state_d = DELIVER;
            end
            DELIVER: begin
                pop     = (count_q != '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_o <= 1'b0;
            valid_q    <= 1'b0;
            msg_q      <= reset_SB_msg();
            data_q     <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= pop;
            msg_q   <= pop ? head_msg : reset_SB_msg();
            data_q  <= pop ? head_data : '0;
            if (flush_i) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count_q    <= '0;
                overflow_o <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (push && !pop)
                    count_q <= count_q + CW'(1);
                else if (pop && !push)
                    count_q <= count_q - CW'(1);
                if (drop)
                    overflow_o <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_100MHz) begin
        if (!reset && push)
            mem[wr_ptr] <= {bus.deser_msg_i, bus.deser_data_i};
    end

    assign count_o               = count_q;
    assign bus.SB_RX_msg_o       = msg_q;
    assign bus.SB_RX_dataBus_o   = data_q;
    assign bus.SB_RX_msg_valid_o = valid_q;

endmodule

// File: tb/tb_sb_rx_msg_queue.sv
// Directed testbench for sb_rx_msg_queue (DEPTH=4).
// Drives and samples on the falling clock edge.
module tb_sb_rx_msg_queue;
    import sb_pkg::*;

    localparam int DEPTH = 4;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       enable_i;
    logic       flush_i;
    logic [2:0] count_o;
    logic       overflow_o;

    int vectors;
    int miscompares;

    sb_rx_msg_queue_if bus ();

    sb_rx_msg_queue #(.DEPTH(DEPTH)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .enable_i   (enable_i),
        .flush_i    (flush_i),
        .bus        (bus.slave),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic SB_msg_t mk(SB_msg_num_t n, logic [15:0] info);
        SB_msg_t m;
        m.msg_num  = n;
        m.msg_info = info;
        return m;
    endfunction

    task automatic tick();
        @(negedge clk_100MHz);
    endtask

    task automatic do_reset();
        reset                = 1'b1;
        flush_i              = 1'b0;
        bus.SB_RX_msg_req_i  = 1'b0;
        bus.deser_valid_i    = 1'b0;
        bus.deser_msg_i      = reset_SB_msg();
        bus.deser_data_i     = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input SB_msg_t m, input logic [63:0] d);
        bus.deser_msg_i   = m;
        bus.deser_data_i  = d;
        bus.deser_valid_i = 1'b1;
        tick();
        bus.deser_valid_i = 1'b0;
        bus.deser_msg_i   = reset_SB_msg();
        bus.deser_data_i  = '0;
    endtask

    // One request pulse, then watch 'win' cycles for delivery strobes.
    task automatic request(input int win, output int nvalid,
                           output SB_msg_t m, output logic [63:0] d,
                           output int lat);
        bus.SB_RX_msg_req_i = 1'b1;
        tick();
        bus.SB_RX_msg_req_i = 1'b0;
        nvalid = 0;
        lat    = 0;
        m      = reset_SB_msg();
        d      = '0;
        for (int i = 1; i <= win; i++) begin
            if (bus.SB_RX_msg_valid_o) begin
                if (nvalid == 0) begin
                    m   = bus.SB_RX_msg_o;
                    d   = bus.SB_RX_dataBus_o;
                    lat = i;
                end
                nvalid++;
            end
            if (i < win) tick();
        end
    endtask

    task automatic test_reset();
        enable_i = 1'b1;
        do_reset();
        vectors++;
        if (count_o !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_count got %0d want 0", count_o);
        end
        vectors++;
        if (overflow_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_overflow got %b want 0", overflow_o);
        end
        vectors++;
        if (bus.SB_RX_msg_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid got %b want 0", bus.SB_RX_msg_valid_o);
        end
        vectors++;
        if (bus.SB_RX_msg_o !== reset_SB_msg()) begin
            miscompares++;
            $display("FAIL reset_msg got %h want %h",
                     bus.SB_RX_msg_o, reset_SB_msg());
        end
        vectors++;
        if (bus.SB_RX_dataBus_o !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_data got %h want 0", bus.SB_RX_dataBus_o);
        end
    endtask

    task automatic test_single();
        SB_msg_t     em;
        SB_msg_t     m;
        logic [63:0] d;
        int          nv;
        int          lat;
        em = mk(SBINIT_out_of_reset, 16'h1234);
        push(em, 64'hDEAD_BEEF_0000_0001);
        vectors++;
        if (count_o !== 3'd1) begin
            miscompares++;
            $display("FAIL single_count_pre got %0d want 1", count_o);
        end
        request(4, nv, m, d, lat);
        vectors++;
        if (nv !== 1) begin
            miscompares++;
            $display("FAIL single_strobes got %0d want 1", nv);
        end
        vectors++;
        if (m !== em || d !== 64'hDEAD_BEEF_0000_0001) begin
            miscompares++;
            $display("FAIL single_payload got %h/%h want %h/%h",
                     m, d, em, 64'hDEAD_BEEF_0000_0001);
        end
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL single_latency got %0d want 2", lat);
        end
        vectors++;
        if (count_o !== 3'd0) begin
            miscompares++;
            $display("FAIL single_count_post got %0d want 0", count_o);
        end
        vectors++;
        if (bus.SB_RX_msg_o !== reset_SB_msg() ||
            bus.SB_RX_dataBus_o !== 64'd0) begin
            miscompares++;
            $display("FAIL single_idle_out got %h/%h want %h/0",
                     bus.SB_RX_msg_o, bus.SB_RX_dataBus_o, reset_SB_msg());
        end
    endtask

    task automatic test_wait();
        SB_msg_t em;
        SB_msg_t m;
        int      early;
        int      nv;
        int      first;
        do_reset();
        em    = mk(SBINIT_done_req, 16'h0042);
        early = 0;
        bus.SB_RX_msg_req_i = 1'b1;
        tick();
        bus.SB_RX_msg_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.SB_RX_msg_req_i = (i == 1);
            if (bus.SB_RX_msg_valid_o) early++;
            tick();
        end
        bus.SB_RX_msg_req_i = 1'b0;
        vectors++;
        if (early !== 0) begin
            miscompares++;
            $display("FAIL wait_early got %0d strobes want 0", early);
        end
        push(em, 64'h5555);
        nv    = 0;
        first = -1;
        m     = reset_SB_msg();
        for (int k = 0; k < 6; k++) begin
            if (bus.SB_RX_msg_valid_o) begin
                if (nv == 0) begin
                    first = k;
                    m     = bus.SB_RX_msg_o;
                end
                nv++;
            end
            tick();
        end
        vectors++;
        if (nv !== 1) begin
            miscompares++;
            $display("FAIL wait_strobes got %0d want 1", nv);
        end
        vectors++;
        if (first !== 2 || m !== em) begin
            miscompares++;
            $display("FAIL wait_delivery got at %0d msg %h want at 2 msg %h",
                     first, m, em);
        end
    endtask

    task automatic test_overflow();
        SB_msg_t     m;
        logic [63:0] d;
        int          nv;
        int          lat;
        do_reset();
        for (int i = 1; i <= 5; i++)
            push(mk(MBINIT_param_req, 16'(i)), 64'h100 + 64'(i));
        vectors++;
        if (count_o !== 3'd4) begin
            miscompares++;
            $display("FAIL ovf_count got %0d want 4", count_o);
        end
        vectors++;
        if (overflow_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_flag got %b want 1", overflow_o);
        end
        for (int i = 1; i <= 4; i++) begin
            request(4, nv, m, d, lat);
            vectors++;
            if (nv !== 1 || m !== mk(MBINIT_param_req, 16'(i)) ||
                d !== 64'h100 + 64'(i)) begin
                miscompares++;
                $display("FAIL ovf_order%0d got %0d/%h/%h want 1/%h/%h",
                         i, nv, m, d, mk(MBINIT_param_req, 16'(i)),
                         64'h100 + 64'(i));
            end
        end
        request(5, nv, m, d, lat);
        vectors++;
        if (nv !== 0 || count_o !== 3'd0) begin
            miscompares++;
            $display("FAIL ovf_lost got %0d strobes cnt %0d want 0/0",
                     nv, count_o);
        end
        vectors++;
        if (overflow_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky got %b want 1", overflow_o);
        end
    endtask

    task automatic test_full_pop();
        SB_msg_t     m;
        logic [63:0] d;
        int          nv;
        int          lat;
        do_reset();
        for (int i = 0; i < 4; i++)
            push(mk(MBINIT_param_resp, 16'h10 + 16'(i)), 64'(i));
        bus.SB_RX_msg_req_i = 1'b1;
        tick();
        bus.SB_RX_msg_req_i = 1'b0;
        bus.deser_msg_i     = mk(MBINIT_param_resp, 16'h14);
        bus.deser_data_i    = 64'd4;
        bus.deser_valid_i   = 1'b1;
        tick();
        bus.deser_valid_i   = 1'b0;
        vectors++;
        if (bus.SB_RX_msg_valid_o !== 1'b1 ||
            bus.SB_RX_msg_o !== mk(MBINIT_param_resp, 16'h10)) begin
            miscompares++;
            $display("FAIL fullpop_head got %b/%h want 1/%h",
                     bus.SB_RX_msg_valid_o, bus.SB_RX_msg_o,
                     mk(MBINIT_param_resp, 16'h10));
        end
        vectors++;
        if (count_o !== 3'd4 || overflow_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fullpop_state got cnt %0d ovf %b want 4/0",
                     count_o, overflow_o);
        end
        for (int i = 1; i <= 4; i++) begin
            request(4, nv, m, d, lat);
            vectors++;
            if (nv !== 1 || m !== mk(MBINIT_param_resp, 16'h10 + 16'(i)) ||
                d !== 64'(i)) begin
                miscompares++;
                $display("FAIL fullpop_order%0d got %0d/%h/%h want 1/%h/%0d",
                         i, nv, m, d,
                         mk(MBINIT_param_resp, 16'h10 + 16'(i)), i);
            end
        end
    endtask

    task automatic test_flush();
        SB_msg_t     em;
        SB_msg_t     m;
        logic [63:0] d;
        int          nv;
        int          lat;
        do_reset();
        for (int i = 0; i < 5; i++)
            push(mk(SBINIT_done_resp, 16'(i)), 64'(i));
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        vectors++;
        if (count_o !== 3'd0 || overflow_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear got cnt %0d ovf %b want 0/0",
                     count_o, overflow_o);
        end
        flush_i           = 1'b1;
        bus.deser_msg_i   = mk(SBINIT_done_resp, 16'h77);
        bus.deser_valid_i = 1'b1;
        tick();
        flush_i           = 1'b0;
        bus.deser_valid_i = 1'b0;
        vectors++;
        if (count_o !== 3'd0) begin
            miscompares++;
            $display("FAIL flush_priority got cnt %0d want 0", count_o);
        end
        request(6, nv, m, d, lat);
        vectors++;
        if (nv !== 0) begin
            miscompares++;
            $display("FAIL flush_nodeliver got %0d strobes want 0", nv);
        end
        em = mk(SBINIT_done_req, 16'h0099);
        push(em, 64'hABCD);
        nv = 0;
        m  = reset_SB_msg();
        for (int k = 0; k < 4; k++) begin
            if (bus.SB_RX_msg_valid_o) begin
                if (nv == 0) m = bus.SB_RX_msg_o;
                nv++;
            end
            tick();
        end
        vectors++;
        if (nv !== 1 || m !== em) begin
            miscompares++;
            $display("FAIL flush_newmsg got %0d/%h want 1/%h", nv, m, em);
        end
    endtask

    task automatic test_enable();
        SB_msg_t     m;
        logic [63:0] d;
        int          nv;
        int          lat;
        do_reset();
        enable_i = 1'b0;
        push(mk(SBINIT_out_of_reset, 16'h1), 64'h1);
        request(4, nv, m, d, lat);
        vectors++;
        if (nv !== 0 || count_o !== 3'd1) begin
            miscompares++;
            $display("FAIL en_ignore got %0d strobes cnt %0d want 0/1",
                     nv, count_o);
        end
        do_reset();
        enable_i = 1'b1;
        bus.SB_RX_msg_req_i = 1'b1;
        tick();
        bus.SB_RX_msg_req_i = 1'b0;
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        push(mk(SBINIT_out_of_reset, 16'h2), 64'h2);
        nv = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.SB_RX_msg_valid_o) nv++;
            tick();
        end
        vectors++;
        if (nv !== 0 || count_o !== 3'd1) begin
            miscompares++;
            $display("FAIL en_waitdrop got %0d strobes cnt %0d want 0/1",
                     nv, count_o);
        end
        request(4, nv, m, d, lat);
        vectors++;
        if (nv !== 1 || m !== mk(SBINIT_out_of_reset, 16'h2) || lat !== 2) begin
            miscompares++;
            $display("FAIL en_kept got %0d/%h lat %0d want 1/%h lat 2",
                     nv, m, lat, mk(SBINIT_out_of_reset, 16'h2));
        end
    endtask

    task automatic test_reset_deliver();
        int nv;
        do_reset();
        push(mk(SBINIT_done_req, 16'h3), 64'h33);
        bus.SB_RX_msg_req_i = 1'b1;
        tick();
        bus.SB_RX_msg_req_i = 1'b0;
        reset = 1'b1;
        tick();
        vectors++;
        if (bus.SB_RX_msg_valid_o !== 1'b0 ||
            bus.SB_RX_msg_o !== reset_SB_msg() ||
            bus.SB_RX_dataBus_o !== 64'd0) begin
            miscompares++;
            $display("FAIL rstdel_out got %b/%h/%h want 0/%h/0",
                     bus.SB_RX_msg_valid_o, bus.SB_RX_msg_o,
                     bus.SB_RX_dataBus_o, reset_SB_msg());
        end
        vectors++;
        if (count_o !== 3'd0 || overflow_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rstdel_state got cnt %0d ovf %b want 0/0",
                     count_o, overflow_o);
        end
        reset = 1'b0;
        nv = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.SB_RX_msg_valid_o) nv++;
            tick();
        end
        vectors++;
        if (nv !== 0) begin
            miscompares++;
            $display("FAIL rstdel_nostrobe got %0d want 0", nv);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        enable_i    = 1'b1;
        flush_i     = 1'b0;
        bus.SB_RX_msg_req_i = 1'b0;
        bus.deser_valid_i   = 1'b0;
        bus.deser_msg_i     = reset_SB_msg();
        bus.deser_data_i    = '0;
        tick();
        test_reset();
        test_single();
        test_wait();
        test_overflow();
        test_full_pop();
        test_flush();
        test_enable();
        test_reset_deliver();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
